cpu_wb_master: RTL and testbench
================================

# cpu_wb_master

Bridge between the multi-cycle CPU memory port and Wishbone master port 0 of the shared interconnect. It accepts one CPU access at a time over a four-phase level handshake and runs one single-beat Wishbone classic cycle. It returns the read data and a held ready level, so the slower CPU clock never misses the completion. A watchdog closes any cycle that no slave acknowledges and flags a bus error.

## Interface
- TIMEOUT_CYCLES, 255: maximum bus cycles that `wb_stb_o` stays high without `wb_ack_i`; legal range 2..65535.
- ERR_DATA, 32'hDEAD_BEEF: value returned on `cpu_rdata` after a timeout.
- clk  in  1  system clock; the only clock in this block.
- rst  in  1  reset, synchronous and active-high.
- cpu_req  in  1  CPU access request (CPU_MIO); held high until `cpu_ready`.
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- cpu_addr  in  32  byte address; stable while `cpu_req` is high.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while `cpu_ready` is high.
- cpu_ready  out  1  access complete; held high until `cpu_req` falls.
- cpu_err  out  1  this access timed out; same timing as `cpu_ready`.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte selects; always 4'hF during a cycle, 4'h0 otherwise.
- wb_we_o  out  1  Wishbone write enable.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle; identical to `wb_stb_o`.
- wb_ack_i  in  1  slave acknowledge.

## Operation
- FSM has three states: IDLE, BUS, DONE.
- **IDLE**
  - When `cpu_req`=1, register `cpu_addr`, `cpu_wdata` and `cpu_we` onto the Wishbone outputs, assert stb/cyc/sel, clear the watchdog and go to BUS.
  - `wb_ack_i` is ignored in IDLE.
- **BUS**
  - On `wb_ack_i`=1: drop stb/cyc/sel and go to DONE with `cpu_ready`=1 and `cpu_err`=0.
  - On a read, capture `wb_dat_i` into `cpu_rdata`. On a write, `cpu_rdata` keeps its previous value.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 with no ack, drop stb/cyc/sel and go to DONE with `cpu_ready`=1, `cpu_err`=1 and `cpu_rdata`=ERR_DATA (reads and writes alike).
  - If ack and the final watchdog count arrive together, ack wins.
- **DONE**
  - Hold `cpu_ready`, `cpu_err` and `cpu_rdata` while `cpu_req`=1.
  - When `cpu_req`=0, clear `cpu_ready` and `cpu_err` and go to IDLE.
  - A still-high `cpu_req` never starts a second access; the request must fall first.
- The watchdog is 16 bits wide and saturates; it never wraps.
- Address and data pass through untranslated; slave decode belongs to the interconnect.

## Timing
- Reset: state=IDLE; every output is 0 (including `cpu_rdata` and `wb_adr_o`); watchdog=0.
- Reset during BUS or DONE takes effect at the next edge: stb/cyc drop and any in-flight ack is discarded.
- `cpu_req` rises in cycle N → stb/cyc are high in cycle N+1.
- Ack seen at edge K → `cpu_ready` is high and stb is low in cycle K+1.
- A zero-wait-state slave (ack in the first stb cycle) gives request-to-ready in 2 cycles.
- A timeout holds stb for exactly TIMEOUT_CYCLES cycles; `cpu_ready` rises on the following cycle.
- `cpu_req` falls in cycle M → `cpu_ready` is low in cycle M+1.
- The earliest next strobe is cycle M+2.
- stb is never high for two back-to-back accesses without an idle cycle between them.

## Structure
- Package `cpu_wb_pkg` holds:
  - the state encoding (IDLE=2'd0, BUS=2'd1, DONE=2'd2);
  - the constants SEL_ALL=4'hF and the default ERR_DATA.
- Sub-module `wb_watchdog`: a clear/enable saturating counter with a `expired` compare output, parameterised by TIMEOUT_CYCLES.
- Everything else is a single always block for the FSM plus registered outputs.

## Test plan
- **Read, 0 wait:** req with addr 32'h0000_0010, slave acks in the first stb cycle with 32'h1234_5678 → `cpu_ready` 2 cycles after req; `cpu_rdata`=32'h1234_5678; `cpu_err`=0.
- **Write, 3 waits:** req with we=1, addr 32'hFFFF_FE00, wdata 32'hA5A5_0001 → stb held 4 cycles with `wb_dat_o`=32'hA5A5_0001 and `wb_sel_o`=4'hF; `cpu_ready` rises the cycle after ack.
- **Timeout:** TIMEOUT_CYCLES=8, no ack → stb high for exactly 8 cycles, then `cpu_ready`=1, `cpu_err`=1 and `cpu_rdata`=32'hDEAD_BEEF.
- **Held request:** `cpu_req` kept high for 20 cycles after ready → exactly one Wishbone cycle and `cpu_ready` held for all 20 cycles; after req falls and rises again, a second cycle starts.
- **Ack/timeout tie:** ack arrives in the final watchdog cycle → `cpu_err`=0 and the read data is returned.
- **Reset mid-cycle:** `rst` pulsed during BUS while the slave acks the same cycle → all outputs 0 next cycle, no `cpu_ready`, FSM in IDLE.

Source files
------------

// File: rtl/cpu_wb_pkg.sv
// rtl/cpu_wb_pkg.sv - shared types and constants for the CPU-to-Wishbone bridge
package cpu_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [3:0]  SEL_ALL          = 4'hF;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - saturating bus-cycle watchdog with expiry compare
module wb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/cpu_wb_master.sv
// rtl/cpu_wb_master.sv - four-phase CPU port to single-beat Wishbone classic master
module cpu_wb_master
   import cpu_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        cpu_err,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i
);

   state_e      state_q, state_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        we_q, we_d;
   logic        stb_q, stb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic        wd_clr;
   logic        wd_en;
   logic        wd_expired;

   wb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expired_o(wd_expired)
   );

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      stb_d   = stb_q;
      rdata_d = rdata_q;
      ready_d = ready_q;
      err_d   = err_q;
      wd_clr  = 1'b0;
      wd_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cpu_req) begin
               adr_d   = cpu_addr;
               dat_d   = cpu_wdata;
               we_d    = cpu_we;
               stb_d   = 1'b1;
               wd_clr  = 1'b1;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            // Ack is tested first so a same-cycle ack beats the final watchdog count.
            if (wb_ack_i) begin
               stb_d   = 1'b0;
               ready_d = 1'b1;
               err_d   = 1'b0;
               if (!we_q) begin
                  rdata_d = wb_dat_i;
               end
               state_d = ST_DONE;
            end else if (wd_expired) begin
               stb_d   = 1'b0;
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = ERR_DATA;
               state_d = ST_DONE;
            end else begin
               wd_en = 1'b1;
            end
         end
         ST_DONE: begin
            if (!cpu_req) begin
               ready_d = 1'b0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            stb_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         stb_q   <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         stb_q   <= stb_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign cpu_rdata = rdata_q;
   assign cpu_ready = ready_q;
   assign cpu_err   = err_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_we_o   = we_q;
   assign wb_stb_o  = stb_q;
   assign wb_cyc_o  = stb_q;
   assign wb_sel_o  = stb_q ? SEL_ALL : 4'h0;

endmodule

// File: tb/tb_cpu_wb_master.sv
// tb/tb_cpu_wb_master.sv - directed self-checking bench for cpu_wb_master
module tb_cpu_wb_master;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_err;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;

   int n_cmp;
   int n_fail;

   cpu_wb_master #(
      .TIMEOUT_CYCLES(8),
      .ERR_DATA      (32'hDEAD_BEEF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready),
      .cpu_err  (cpu_err),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_sel_o (wb_sel_o),
      .wb_we_o  (wb_we_o),
      .wb_stb_o (wb_stb_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_ack_i (wb_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      wb_dat_i = '0; wb_ack_i = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({cpu_rdata, wb_adr_o, wb_dat_o} !== 96'h0) begin
         n_fail++;
         $display("FAIL reset_data: rdata=%h adr=%h dat=%h required all 0", cpu_rdata, wb_adr_o, wb_dat_o);
      end
      n_cmp++;
      if ({cpu_ready, cpu_err, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o} !== 9'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready=%b err=%b sel=%h we=%b stb=%b cyc=%b required all 0",
                  cpu_ready, cpu_err, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read_zero_wait();
      cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_req = 1'b1;
      tick();
      n_cmp++;
      if ({wb_stb_o, wb_cyc_o, wb_sel_o, wb_we_o, cpu_ready} !== 8'b1_1_1111_0_0) begin
         n_fail++;
         $display("FAIL read0_strobe: stb=%b cyc=%b sel=%h we=%b ready=%b required 1 1 f 0 0",
                  wb_stb_o, wb_cyc_o, wb_sel_o, wb_we_o, cpu_ready);
      end
      n_cmp++;
      if (wb_adr_o !== 32'h0000_0010) begin
         n_fail++;
         $display("FAIL read0_addr: got %h required 00000010", wb_adr_o);
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
      tick();
      wb_ack_i = 1'b0; wb_dat_i = '0;
      n_cmp++;
      if ({cpu_ready, cpu_err, wb_stb_o, wb_sel_o} !== 7'b1_0_0_0000) begin
         n_fail++;
         $display("FAIL read0_done: ready=%b err=%b stb=%b sel=%h required 1 0 0 0",
                  cpu_ready, cpu_err, wb_stb_o, wb_sel_o);
      end
      n_cmp++;
      if (cpu_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL read0_rdata: got %h required 12345678", cpu_rdata);
      end
      cpu_req = 1'b0;
      tick();
      n_cmp++;
      if (cpu_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL read0_release: ready=%b required 0", cpu_ready);
      end
   endtask

   task automatic test_write_waits();
      int bad;
      bad = 0;
      cpu_we = 1'b1; cpu_addr = 32'hFFFF_FE00; cpu_wdata = 32'hA5A5_0001; cpu_req = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (!(wb_stb_o === 1'b1 && wb_dat_o === 32'hA5A5_0001 && wb_sel_o === 4'hF &&
               wb_we_o === 1'b1 && wb_adr_o === 32'hFFFF_FE00 && cpu_ready === 1'b0)) bad++;
         if (i == 3) wb_ack_i = 1'b1;
         tick();
      end
      wb_ack_i = 1'b0;
      n_cmp++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL write_bus: %0d bad strobe cycles required 0", bad);
      end
      n_cmp++;
      if ({cpu_ready, cpu_err, wb_stb_o, wb_cyc_o} !== 4'b1000) begin
         n_fail++;
         $display("FAIL write_done: ready=%b err=%b stb=%b cyc=%b required 1 0 0 0",
                  cpu_ready, cpu_err, wb_stb_o, wb_cyc_o);
      end
      n_cmp++;
      if (cpu_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL write_rdata_kept: got %h required 12345678", cpu_rdata);
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int n_stb;
      n_stb = 0;
      cpu_we = 1'b0; cpu_addr = 32'h0000_4000; cpu_req = 1'b1;
      tick();
      while (wb_stb_o === 1'b1 && n_stb < 40) begin
         n_stb++;
         tick();
      end
      n_cmp++;
      if (n_stb !== 8) begin
         n_fail++;
         $display("FAIL timeout_len: stb cycles=%0d required 8", n_stb);
      end
      n_cmp++;
      if ({cpu_ready, cpu_err} !== 2'b11) begin
         n_fail++;
         $display("FAIL timeout_flags: ready=%b err=%b required 1 1", cpu_ready, cpu_err);
      end
      n_cmp++;
      if (cpu_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL timeout_rdata: got %h required deadbeef", cpu_rdata);
      end
      cpu_req = 1'b0;
      tick();
      n_cmp++;
      if ({cpu_ready, cpu_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_release: ready=%b err=%b required 0 0", cpu_ready, cpu_err);
      end
   endtask

   task automatic test_held_request();
      int n_ready;
      int n_stb;
      n_ready = 0; n_stb = 0;
      cpu_we = 1'b0; cpu_addr = 32'h0000_0020; cpu_req = 1'b1;
      tick();
      wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
      tick();
      wb_ack_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cpu_ready === 1'b1) n_ready++;
         if (wb_stb_o !== 1'b0) n_stb++;
         tick();
      end
      n_cmp++;
      if (n_ready !== 20) begin
         n_fail++;
         $display("FAIL held_ready: ready cycles=%0d required 20", n_ready);
      end
      n_cmp++;
      if (n_stb !== 0) begin
         n_fail++;
         $display("FAIL held_no_restart: stb cycles=%0d required 0", n_stb);
      end
      cpu_req = 1'b0;
      tick();
      n_cmp++;
      if ({cpu_ready, wb_stb_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL held_drop: ready=%b stb=%b required 0 0", cpu_ready, wb_stb_o);
      end
      cpu_req = 1'b1; cpu_addr = 32'h0000_0024;
      tick();
      n_cmp++;
      if ({wb_stb_o, wb_adr_o} !== {1'b1, 32'h0000_0024}) begin
         n_fail++;
         $display("FAIL held_second: stb=%b adr=%h required 1 00000024", wb_stb_o, wb_adr_o);
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0024;
      tick();
      wb_ack_i = 1'b0;
      cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_tie();
      cpu_we = 1'b0; cpu_addr = 32'h0000_0030; cpu_req = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) tick();
      wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
      n_cmp++;
      if (wb_stb_o !== 1'b1) begin
         n_fail++;
         $display("FAIL tie_stb_last: stb=%b required 1", wb_stb_o);
      end
      tick();
      wb_ack_i = 1'b0;
      n_cmp++;
      if ({cpu_ready, cpu_err, wb_stb_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL tie_flags: ready=%b err=%b stb=%b required 1 0 0", cpu_ready, cpu_err, wb_stb_o);
      end
      n_cmp++;
      if (cpu_rdata !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL tie_rdata: got %h required cafef00d", cpu_rdata);
      end
      cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h1111_2222; cpu_req = 1'b1;
      tick();
      tick();
      rst = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
      tick();
      rst = 1'b0; wb_ack_i = 1'b0; cpu_req = 1'b0;
      n_cmp++;
      if ({cpu_rdata, wb_adr_o, wb_dat_o} !== 96'h0) begin
         n_fail++;
         $display("FAIL rstmid_data: rdata=%h adr=%h dat=%h required all 0", cpu_rdata, wb_adr_o, wb_dat_o);
      end
      n_cmp++;
      if ({cpu_ready, cpu_err, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o} !== 9'h0) begin
         n_fail++;
         $display("FAIL rstmid_ctrl: ready=%b err=%b sel=%h we=%b stb=%b cyc=%b required all 0",
                  cpu_ready, cpu_err, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o);
      end
      n_cmp++;
      if (dut.state_q !== 2'd0) begin
         n_fail++;
         $display("FAIL rstmid_state: state=%0d required 0", dut.state_q);
      end
      tick();
      n_cmp++;
      if ({cpu_ready, wb_stb_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_after: ready=%b stb=%b required 0 0", cpu_ready, wb_stb_o);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_read_zero_wait();
      test_write_waits();
      test_timeout();
      test_held_request();
      test_tie();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
